// File: rtl/wr_ctrl_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: width/depth derivation and Gray conversions.
// Functions work on 32-bit vectors; callers cast to their own pointer width.
package wr_ctrl_pkg;

  localparam int FUNC_W = 32;

  function automatic int ptr_width(input int ptr_msb);
    return ptr_msb + 1;
  endfunction

  function automatic int fifo_depth(input int ptr_msb);
    return 1 << ptr_msb;
  endfunction

  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] gray);
    logic [FUNC_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < FUNC_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
// Shared by the write and read pointer controllers.
module wr_ctrl_gray2bin #(
  parameter int P_W = 5
) (
  input  logic [P_W-1:0] gray,
  output logic [P_W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < P_W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_ctrl.sv
// Write-domain pointer/flag controller for the dual-clock FIFO; one-cycle flag/level latency.
// Optional sticky overflow flag is built only when WR_CTRL_OVERFLOW_EN is defined.
module wr_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int P_PTR_MSB      = 4,
  parameter int P_AFULL_THRESH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  input  logic [P_PTR_MSB:0]   i_rd_ptr_gray,
  input  logic                 i_ovf_clr,
  output logic                 o_wr_en,
  output logic [P_PTR_MSB-1:0] o_wr_addr,
  output logic [P_PTR_MSB:0]   o_wr_ptr_gray,
  output logic                 o_full,
  output logic                 o_afull,
  output logic [P_PTR_MSB:0]   o_level,
  output logic                 o_overflow
);

  localparam int PTR_W = ptr_width(P_PTR_MSB);
  localparam logic [PTR_W-1:0] AFULL_THRESH = PTR_W'(P_AFULL_THRESH);

  logic [PTR_W-1:0] bin_ptr;
  logic [PTR_W-1:0] gray_ptr;
  logic [PTR_W-1:0] level;
  logic             full;
  logic             afull;

  logic             wr_en;
  logic [PTR_W-1:0] bin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_gray;

  wr_ctrl_gray2bin #(
    .P_W (PTR_W)
  ) u_rd_gray2bin (
    .gray (i_rd_ptr_gray),
    .bin  (rd_bin)
  );

  // Only the registered full flag gates writes; the read pointer never reaches wr_en directly.
  assign wr_en      = i_inc & ~full;
  assign bin_next   = bin_ptr + PTR_W'(wr_en);
  assign gray_next  = PTR_W'(bin2gray(FUNC_W'(bin_next)));
  assign level_next = bin_next - rd_bin;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_gray = {~i_rd_ptr_gray[P_PTR_MSB -: 2], i_rd_ptr_gray[P_PTR_MSB-2:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      level    <= '0;
      full     <= 1'b0;
      afull    <= 1'b0;
    end else begin
      bin_ptr  <= bin_next;
      gray_ptr <= gray_next;
      level    <= level_next;
      full     <= (gray_next == full_gray);
      afull    <= (level_next >= AFULL_THRESH);
    end
  end

`ifdef WR_CTRL_OVERFLOW_EN
  logic overflow;

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (i_inc && full) begin
      overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign o_overflow = overflow;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = i_ovf_clr;
  assign o_overflow     = 1'b0;
`endif

  assign o_wr_en       = wr_en;
  assign o_wr_addr     = bin_ptr[P_PTR_MSB-1:0];
  assign o_wr_ptr_gray = gray_ptr;
  assign o_full        = full;
  assign o_afull       = afull;
  assign o_level       = level;

endmodule

// File: tb/tb_wr_ctrl.sv
// Directed self-checking bench for wr_ctrl (P_PTR_MSB=4, P_AFULL_THRESH=12).
// Inputs change 1 ns after posedge; outputs are sampled 1-2 ns after posedge.
module tb_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       inc;
  logic [4:0] rd_gray;
  logic       ovf_clr;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       full;
  logic       afull;
  logic [4:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wr_ctrl #(
    .P_PTR_MSB      (4),
    .P_AFULL_THRESH (12)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_inc         (inc),
    .i_rd_ptr_gray (rd_gray),
    .i_ovf_clr     (ovf_clr),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_ptr_gray (wr_gray),
    .o_full        (full),
    .o_afull       (afull),
    .o_level       (level),
    .o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; inc = 1'b0; rd_gray = '0; ovf_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inc = 1'b0; rd_gray = '0; ovf_clr = 1'b0;
    tick(); tick();
    n_checks++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL reset_wr_en: got %0h want 0", wr_en); end
    n_checks++; if (wr_addr !== 4'd0)  begin n_fail++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    n_checks++; if (wr_gray !== 5'd0)  begin n_fail++; $display("FAIL reset_wr_gray: got %0h want 0", wr_gray); end
    n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %0h want 0", full); end
    n_checks++; if (afull !== 1'b0)    begin n_fail++; $display("FAIL reset_afull: got %0h want 0", afull); end
    n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL reset_level: got %0h want 0", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    rd_gray = '0;
    inc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_checks++; if (wr_en !== 1'b1)       begin n_fail++; $display("FAIL fill_wr_en[%0d]: got %0h want 1", i, wr_en); end
      n_checks++; if (wr_addr !== 4'(i))    begin n_fail++; $display("FAIL fill_wr_addr[%0d]: got %0d want %0d", i, wr_addr, i); end
      tick();
      n_checks++; if (level !== 5'(i + 1))  begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); end
    end
    inc = 1'b0;
    n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL fill_full: got %0h want 1", full); end
    n_checks++; if (afull !== 1'b1)       begin n_fail++; $display("FAIL fill_afull: got %0h want 1", afull); end
    n_checks++; if (level !== 5'd16)      begin n_fail++; $display("FAIL fill_level16: got %0d want 16", level); end
    n_checks++; if (wr_gray !== 5'b11000) begin n_fail++; $display("FAIL fill_wr_gray: got %b want 11000", wr_gray); end
  endtask

  task automatic test_full_hold();
    inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (wr_en !== 1'b0)       begin n_fail++; $display("FAIL hold_wr_en[%0d]: got %0h want 0", i, wr_en); end
      tick();
      n_checks++; if (wr_gray !== 5'b11000) begin n_fail++; $display("FAIL hold_wr_gray[%0d]: got %b want 11000", i, wr_gray); end
      n_checks++; if (level !== 5'd16)      begin n_fail++; $display("FAIL hold_level[%0d]: got %0d want 16", i, level); end
      n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL hold_full[%0d]: got %0h want 1", i, full); end
`ifdef WR_CTRL_OVERFLOW_EN
      n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL hold_overflow[%0d]: got %0h want 1", i, overflow); end
`else
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL hold_overflow[%0d]: got %0h want 0", i, overflow); end
`endif
    end
    inc = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0h want 0", overflow); end
    // set and clear together
    inc = 1'b1; ovf_clr = 1'b1;
    tick();
    inc = 1'b0; ovf_clr = 1'b0;
`ifdef WR_CTRL_OVERFLOW_EN
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0h want 1", overflow); end
`else
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_set_wins: got %0h want 0", overflow); end
`endif
    tick();
    n_checks++; if (wr_gray !== 5'b11000) begin n_fail++; $display("FAIL hold_final_gray: got %b want 11000", wr_gray); end
  endtask

  task automatic test_afull();
    do_reset();
    inc = 1'b1;
    repeat (11) tick();
    inc = 1'b0;
    n_checks++; if (level !== 5'd11) begin n_fail++; $display("FAIL afull_level11: got %0d want 11", level); end
    n_checks++; if (afull !== 1'b0)  begin n_fail++; $display("FAIL afull_at11: got %0h want 0", afull); end
    inc = 1'b1;
    tick();
    inc = 1'b0;
    n_checks++; if (level !== 5'd12) begin n_fail++; $display("FAIL afull_level12: got %0d want 12", level); end
    n_checks++; if (afull !== 1'b1)  begin n_fail++; $display("FAIL afull_at12: got %0h want 1", afull); end
    n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL afull_full12: got %0h want 0", full); end
    rd_gray = 5'b00001;
    tick();
    n_checks++; if (level !== 5'd11) begin n_fail++; $display("FAIL afull_rd_level: got %0d want 11", level); end
    n_checks++; if (afull !== 1'b0)  begin n_fail++; $display("FAIL afull_rd_drop: got %0h want 0", afull); end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    logic [4:0] exp_gray;
    logic [4:0] rd_bin;
    do_reset();
    prev = 5'd0;
    for (int k = 0; k < 40; k++) begin
      rd_bin  = (k >= 3) ? 5'(k - 3) : 5'd0;
      rd_gray = to_gray(rd_bin);
      inc     = 1'b1;
      #1;
      n_checks++; if (wr_en !== 1'b1)    begin n_fail++; $display("FAIL wrap_wr_en[%0d]: got %0h want 1", k, wr_en); end
      n_checks++; if (wr_addr !== 4'(k)) begin n_fail++; $display("FAIL wrap_wr_addr[%0d]: got %0d want %0d", k, wr_addr, k % 16); end
      tick();
      exp_gray = to_gray(5'(k + 1));
      n_checks++; if (wr_gray !== exp_gray) begin n_fail++; $display("FAIL wrap_gray[%0d]: got %b want %b", k, wr_gray, exp_gray); end
      n_checks++; if ($countones(wr_gray ^ prev) != 1) begin n_fail++; $display("FAIL wrap_onebit[%0d]: got %b prev %b want 1 bit change", k, wr_gray, prev); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full[%0d]: got %0h want 0", k, full); end
      n_checks++; if (level !== ((k >= 3) ? 5'd4 : 5'(k + 1))) begin n_fail++; $display("FAIL wrap_level[%0d]: got %0d want %0d", k, level, (k >= 3) ? 4 : k + 1); end
      prev = exp_gray;
    end
    inc = 1'b0;
  endtask

  task automatic test_full_rd_race();
    do_reset();
    inc = 1'b1;
    repeat (16) tick();
    inc = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL race_full_before: got %0h want 1", full); end
    rd_gray = 5'b00001;
    inc = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL race_dropped: got %0h want 0", wr_en); end
    tick();
    n_checks++; if (full !== 1'b0)        begin n_fail++; $display("FAIL race_full_clear: got %0h want 0", full); end
    n_checks++; if (wr_gray !== 5'b11000) begin n_fail++; $display("FAIL race_gray_held: got %b want 11000", wr_gray); end
    n_checks++; if (level !== 5'd15)      begin n_fail++; $display("FAIL race_level15: got %0d want 15", level); end
    #1;
    n_checks++; if (wr_en !== 1'b1)    begin n_fail++; $display("FAIL race_accept: got %0h want 1", wr_en); end
    n_checks++; if (wr_addr !== 4'd0)  begin n_fail++; $display("FAIL race_addr: got %0d want 0", wr_addr); end
    tick();
    inc = 1'b0;
    n_checks++; if (wr_gray !== 5'b11001) begin n_fail++; $display("FAIL race_gray17: got %b want 11001", wr_gray); end
    n_checks++; if (level !== 5'd16)      begin n_fail++; $display("FAIL race_level16: got %0d want 16", level); end
    n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL race_full_again: got %0h want 1", full); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inc = 1'b1;
    repeat (9) tick();
    n_checks++; if (level !== 5'd9) begin n_fail++; $display("FAIL mid_level9: got %0d want 9", level); end
    rst = 1'b1;
    tick();
    inc = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0)    begin n_fail++; $display("FAIL mid_wr_en: got %0h want 0", wr_en); end
    n_checks++; if (wr_addr !== 4'd0)  begin n_fail++; $display("FAIL mid_wr_addr: got %0d want 0", wr_addr); end
    n_checks++; if (wr_gray !== 5'd0)  begin n_fail++; $display("FAIL mid_wr_gray: got %b want 0", wr_gray); end
    n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL mid_level: got %0d want 0", level); end
    n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL mid_full: got %0h want 0", full); end
    n_checks++; if (afull !== 1'b0)    begin n_fail++; $display("FAIL mid_afull: got %0h want 0", afull); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %0h want 0", overflow); end
    rst = 1'b0;
    tick();
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_idle_level: got %0d want 0", level); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inc = 1'b0; rd_gray = '0; ovf_clr = 1'b0;
    test_reset();
    test_fill();
    test_full_hold();
    test_afull();
    test_wrap();
    test_full_rd_race();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_ctrl.md
Name: wr_ctrl

Overview:
Write-side pointer and flag controller for the generic dual-clock FIFO. It lives entirely in the write clock domain. It produces the RAM write enable/address and a Gray-coded write pointer for crossing to the read domain. It derives full, almost-full and fill level from the read pointer after that pointer has been synchronised into the write domain.

Parameters:
P_PTR_MSB, 4, MSB index of the pointers; pointer width P_PTR_MSB+1; FIFO depth 2**P_PTR_MSB (16). Legal range >= 2.
P_AFULL_THRESH, 12, fill level at or above which o_afull asserts. Legal range 1..2**P_PTR_MSB.

Ports:
i_clk  in  1  write-domain clock
i_rst  in  1  synchronous, active-high reset
i_inc  in  1  write request from the producer
i_rd_ptr_gray  in  P_PTR_MSB+1  read pointer, Gray code, already synchronised into i_clk domain
i_ovf_clr  in  1  clears the sticky overflow flag
o_wr_en  out  1  RAM write strobe (combinational: i_inc & ~o_full)
o_wr_addr  out  P_PTR_MSB  RAM write address = binary pointer [P_PTR_MSB-1:0]
o_wr_ptr_gray  out  P_PTR_MSB+1  registered Gray write pointer, to the read-domain synchroniser
o_full  out  1  registered full flag
o_afull  out  1  registered almost-full flag
o_level  out  P_PTR_MSB+1  registered fill level, 0..2**P_PTR_MSB
o_overflow  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (i_rst=1 at posedge i_clk): binary and Gray pointers 0, o_full 0, o_afull 0, o_level 0, o_overflow 0. Reset overrides i_inc. The read-side controller must be reset in the same window.
- Accept: w_wr_en = i_inc & ~r_full. The RAM writes data at o_wr_addr in the same cycle.
- Next pointer: bin_next = r_bin + w_wr_en, modulo 2**(P_PTR_MSB+1). gray_next = bin_next ^ (bin_next >> 1). Both are registered.
- Full: r_full <= (gray_next == {~rd_gray[MSB:MSB-1], rd_gray[MSB-2:0]}). Computed from the next pointer, so a write that fills the FIFO raises o_full on the very next cycle. No write is ever accepted while full.
- Level: rd_bin = gray-to-binary(i_rd_ptr_gray). r_level <= bin_next - rd_bin, modulo 2**(P_PTR_MSB+1).
- Almost-full: r_afull <= (bin_next - rd_bin) >= P_AFULL_THRESH.
- Latency:
  - A write in cycle n is visible on o_wr_ptr_gray, o_level, o_full and o_afull at cycle n+1.
  - A read-pointer change on the input is reflected one cycle after it appears.
  - Because of the synchroniser delay upstream, o_full and o_afull are pessimistic (they may deassert late). This is by design; they are never optimistic.
- Wrap-around: the binary pointer wraps 2**(P_PTR_MSB+1)-1 -> 0. The Gray pointer changes exactly one bit per accepted write, including across the wrap.
- i_inc while o_full=1: write dropped; pointers, level and flags unchanged except overflow.
- Simultaneous read-pointer advance and write while full: the write is still dropped that cycle. Full clears the next cycle.
- i_rd_ptr_gray is sampled only through the registered flag/level logic. It never feeds o_wr_en except via r_full.

Optional Feature:
Macro WR_CTRL_OVERFLOW_EN.
- Defined: o_overflow sets on any cycle with i_inc=1 and o_full=1, and is visible the next cycle. It holds until i_ovf_clr=1 or reset. If set and clear coincide, set wins.
- Not defined: o_overflow is tied to 0 and i_ovf_clr is ignored. The port list does not change.

Decomposition:
- Shared FIFO package holds:
  - the pointer-width localparam derivation (P_PTR_MSB+1, depth = 1<<P_PTR_MSB);
  - the bin-to-Gray and Gray-to-bin functions, reused by the read side.
- One sub-module is natural: gray2bin, a parameterised combinational XOR-prefix converter instantiated on i_rd_ptr_gray. The read controller uses the same sub-module on the write pointer.

Test Plan:
- Reset then 16 back-to-back writes, rd_ptr_gray=0: o_wr_addr 0..15; o_full=1 the cycle after the 16th write; o_level=16; o_wr_ptr_gray=5'b11000.
- Full, i_inc held 3 cycles: o_wr_en=0, pointer stays 5'b11000. With WR_CTRL_OVERFLOW_EN, o_overflow=1 and it clears one cycle after an i_ovf_clr pulse. Without the macro, o_overflow stays 0.
- Level 11, one write: o_afull rises to 1 at level 12. After rd_ptr_gray advances by 1 (bin 0->1), the next cycle shows o_level=11 and o_afull=0.
- 40 writes interleaved with rd_ptr tracking to level 4: binary pointer wraps 31->0; exactly one bit of o_wr_ptr_gray changes per accepted write; o_full never asserts.
- Full, with rd_ptr advance and i_inc in the same cycle: the write is dropped, o_full=0 next cycle, and a write in the following cycle is accepted.
- i_rst asserted mid-stream at level 9 with i_inc=1: next cycle all outputs are zero and no write is accepted that cycle.
